// File: rtl/pipe_ctrl_carrier.sv
// Pipeline control carrier: moves decoder control bundles through ID/EX,
// EX/MEM and MEM/WB, and produces load-use stall, branch flush bubbles
// and EX-stage forwarding selects for a 5-stage MIPS datapath.
module pipe_ctrl_carrier #(
  parameter int unsigned AW = 5,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [2:0]    id_ex,
  input  logic [2:0]    id_m,
  input  logic [1:0]    id_wb,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [AW-1:0] id_rd,
  input  logic          branch_taken,
  output logic          stall,
  output logic          ex_reg_dst,
  output logic          ex_alu_op,
  output logic          ex_alu_src,
  output logic [AW-1:0] ex_dst,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          mem_branch,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_dst,
  output logic          wb_reg_write,
  output logic          wb_mem_to_reg,
  output logic [AW-1:0] wb_dst,
  output logic [CW-1:0] stall_count
);

  // ID/EX held fields that are not directly exported
  logic [2:0]    ex_m;
  logic [1:0]    ex_wb;
  logic [AW-1:0] ex_rs;
  logic [AW-1:0] ex_rt;
  logic [AW-1:0] ex_rd;

  // EX/MEM write-back bits carried to MEM/WB
  logic [1:0]    mem_wb;

  logic          hz;
  logic          id_ex_bubble;

  // Load in EX whose destination is a source of the ID instruction
  assign hz = id_valid & ex_m[1] & (ex_rt != '0) &
              ((ex_rt == id_rs) | (ex_rt == id_rt));

  // A taken branch squashes the younger instruction, so it never stalls
  assign stall        = hz & ~branch_taken;
  assign id_ex_bubble = branch_taken | hz | ~id_valid;

  assign ex_dst = ex_reg_dst ? ex_rd : ex_rt;

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_reg_dst <= 1'b0;
      ex_alu_op  <= 1'b0;
      ex_alu_src <= 1'b0;
      ex_m       <= '0;
      ex_wb      <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
    end else if (id_ex_bubble) begin
      ex_reg_dst <= 1'b0;
      ex_alu_op  <= 1'b0;
      ex_alu_src <= 1'b0;
      ex_m       <= '0;
      ex_wb      <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
    end else begin
      ex_reg_dst <= id_ex[2];
      ex_alu_op  <= id_ex[1];
      ex_alu_src <= id_ex[0];
      ex_m       <= id_m;
      ex_wb      <= id_wb;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
    end
  end

  // EX/MEM pipeline register; the EX instruction is squashed on a taken branch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_branch <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_wb     <= '0;
      mem_dst    <= '0;
    end else if (branch_taken) begin
      mem_branch <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_wb     <= '0;
      mem_dst    <= '0;
    end else begin
      mem_branch <= ex_m[2];
      mem_read   <= ex_m[1];
      mem_write  <= ex_m[0];
      mem_wb     <= ex_wb;
      mem_dst    <= ex_dst;
    end
  end

  // MEM/WB pipeline register; the branching instruction itself retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_dst        <= '0;
    end else begin
      wb_reg_write  <= mem_wb[1];
      wb_mem_to_reg <= mem_wb[0];
      wb_dst        <= mem_dst;
    end
  end

  // Operand forwarding: the younger producer (EX/MEM) wins, register 0 never forwards
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_wb[1] && (mem_dst != '0) && (mem_dst == ex_rs)) begin
      fwd_a = 2'b10;
    end else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rs)) begin
      fwd_a = 2'b01;
    end
    if (mem_wb[1] && (mem_dst != '0) && (mem_dst == ex_rt)) begin
      fwd_b = 2'b10;
    end else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rt)) begin
      fwd_b = 2'b01;
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CW'(1);
    end
  end

endmodule
